acl_spi_sched: RTL and testbench
================================

# acl_spi_sched

Transaction scheduler and arbiter that owns the ADXL362 SPI pins and shares them between two requesters, for example a configuration sequencer on port 0 and a periodic sample poller on port 1. Each granted request becomes one complete register transaction: a CMD byte, an ADDR byte, then DATA bytes. Read data is returned byte-by-byte with a strobe. The block sits between the accelerometer front end and any logic that needs register access.

## Interface
Parameters:
- TICK, 8: clk_8mhz cycles per SCLK period. Must be even and ≥ 4.
- MAX_LEN, 6: maximum DATA bytes per read burst. Range 1..7.

Ports. Index i selects the requester, i ∈ {0,1}.
- clk_8mhz  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  request valid, bit i for requester i.
- req_ready  out  2  one-cycle grant/accept, bit i for requester i.
- req_wr  in  2  1 = write (CMD 0x0A), 0 = read (CMD 0x0B).
- req_addr  in  16  register address; requester i uses bits [8i+7:8i].
- req_wdata  in  16  write byte; requester i uses bits [8i+7:8i].
- req_len  in  6  read byte count; requester i uses bits [3i+2:3i].
- busy  out  1  high from grant until the end of GAP.
- rd_valid  out  1  one-cycle strobe per received DATA byte.
- rd_data  out  8  received byte, valid while rd_valid is high.
- rd_id  out  1  requester that owns the current read.
- rd_last  out  1  high with rd_valid on the final byte of a burst.
- done  out  1  one-cycle pulse when a transaction completes.
- miso  in  1  SPI data from the slave.
- mosi  out  1  SPI data to the slave.
- sclk  out  1  SPI clock.
- csn  out  1  SPI chip select, active low.

## Operation
- SPI mode 0, MSB first. SCLK idles low.
- Bit period is TICK cycles, numbered b = 0..TICK-1:
  - mosi updates at b = 0.
  - sclk is high for b = TICK/2..TICK-1.
  - miso is sampled at b = TICK/2, the rising edge.
- Byte period is 8·TICK cycles.
- FSM states and transitions:
  - IDLE → CS_SETUP when a request is granted.
  - CS_SETUP (TICK cycles, csn low, sclk low) → CMD.
  - CMD (1 byte) → ADDR.
  - ADDR (1 byte) → DATA.
  - DATA (n bytes) → CS_HOLD.
  - CS_HOLD (TICK cycles, csn low, sclk low) → GAP.
  - GAP (TICK cycles, csn high) → IDLE.
- Arbitration in IDLE only:
  - One valid: grant it.
  - Both valid: grant the requester not granted last.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
- Handshake:
  - req_ready[i] is combinational, high for exactly one IDLE cycle.
  - All req_* fields of requester i are captured on that edge.
  - The requester holds valid and all fields stable until it sees ready.
  - Deasserting valid before ready withdraws the request; this is legal.
- Write: n = 1 regardless of req_len. The DATA byte is the captured wdata. No rd_valid is produced.
- Read: n = req_len, with 0 → 1 and values > MAX_LEN → MAX_LEN. mosi = 0 during DATA.
- Read data is shifted in on each sampling point. The completed byte is presented one cycle after the 8th sample of each DATA byte.
- done pulses on the first GAP cycle, for both reads and writes.

## Timing
- Reset values: csn = 1, sclk = 0, mosi = 0, req_ready = 0, busy = 0, rd_valid = 0, rd_data = 0x00, rd_id = 0, rd_last = 0, done = 0. State resets to IDLE, pointer to 1.
- Grant edge k → csn low and busy high from cycle k+1.
- csn low time = 2·TICK + (2+n)·8·TICK cycles.
- Minimum csn high time between transactions is TICK cycles (GAP). The next grant is possible on the first IDLE cycle after GAP.
- Outputs are registered: csn, sclk, mosi, busy, rd_*, done. req_ready is the only combinational output.
- Reset mid-transaction takes effect asynchronously:
  - csn → 1, sclk → 0, mosi → 0 immediately.
  - No further rd_valid or done.
  - The partial burst is abandoned; the requester re-issues it.
- A request arriving during busy is held pending until IDLE; it is not dropped.
- Both requests arriving on the same IDLE cycle: exactly one ready. The loser is granted after GAP if it is still valid.

## Test plan
- Requester 0 writes 0x02 to 0x2D (TICK = 8):
  - mosi carries 0x0A, 0x2D, 0x02.
  - csn is low for exactly 208 cycles, then high for at least 8.
  - One done pulse, no rd_valid.
- Requester 1 reads len = 6 at 0x0E; the slave model drives 0x11, 0x22, …, 0x66:
  - Six rd_valid strobes in order with rd_id = 1.
  - rd_last is high only with 0x66.
  - csn is low for 528 cycles.
- Both valid on the same cycle, repeated three times:
  - Grants go 0, 1, 0.
  - Exactly one req_ready per IDLE.
  - Transactions never overlap, and csn high ≥ TICK between them.
- Read with len = 0, then len = 7:
  - The first yields 1 byte with rd_last.
  - The second yields 6 bytes (MAX_LEN).
- Assert rst in the 3rd DATA byte of a 6-byte read:
  - Same cycle: csn = 1, sclk = 0, mosi = 0.
  - No done and no further rd_valid.
  - After release, a new read completes normally.
- SCLK and MOSI check across one byte:
  - Exactly 8 rising edges per byte, at b = TICK/2.
  - mosi is stable for the full bit period.
  - sclk is low throughout CS_SETUP, CS_HOLD and GAP.

Source files
------------

// File: rtl/acl_spi_sched.sv
// acl_spi_sched: owns the ADXL362 SPI pins and shares them between two requesters.
// Each grant runs one register transaction: CMD, ADDR, then 1..MAX_LEN DATA bytes.
// SPI mode 0, MSB first.
//
// Ports
//   clk_8mhz, rst           clock; asynchronous active-high reset
//   req_valid/req_ready     per-requester handshake; ready is combinational, one IDLE cycle
//   req_wr/addr/wdata/len   per-requester fields, captured on the grant edge
//   busy                    high from grant until the end of the inter-transaction gap
//   rd_valid/data/id/last   one strobe per received read byte
//   done                    one-cycle pulse on the first gap cycle
//   miso/mosi/sclk/csn      SPI pins
module acl_spi_sched #(
    parameter int unsigned TICK    = 8,
    parameter int unsigned MAX_LEN = 6
) (
    input  logic        clk_8mhz,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [5:0]  req_len,
    output logic        busy,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        rd_id,
    output logic        rd_last,
    output logic        done,
    input  logic        miso,
    output logic        mosi,
    output logic        sclk,
    output logic        csn
);

    localparam int unsigned   TW       = $clog2(TICK);
    localparam logic [TW-1:0] TickLast = TW'(TICK - 1);
    localparam logic [TW-1:0] TickHalf = TW'(TICK / 2);
    localparam logic [2:0]    MaxLen   = 3'(MAX_LEN);

    typedef enum logic [2:0] {
        StIdle, StCsSetup, StCmd, StAddr, StData, StCsHold, StGap
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    left_q, left_d;   // DATA bytes remaining, including the current one
    logic          id_q, id_d;
    logic          last_q, last_d;   // requester granted most recently
    logic          wr_q, wr_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rx_q, rx_d;

    logic          csn_q, csn_d, sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d;
    logic          rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, done_q, done_d;
    logic [7:0]    rd_data_q, rd_data_d;

    logic          grant, gnt_id, shifting, tick_end, byte_end, sending;
    logic [2:0]    len_sel, n_sel;
    logic [7:0]    tx_byte;

    // Arbitration: a tie goes to the requester that was not granted last.
    always_comb begin
        gnt_id    = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        grant     = (state_q == StIdle) && (req_valid != 2'b00) && !rst;
        req_ready = grant ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        left_d     = left_q;
        id_d       = id_q;
        last_d     = last_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rx_d       = rx_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_data_d  = rd_data_q;
        len_sel    = gnt_id ? req_len[5:3] : req_len[2:0];
        n_sel      = len_sel;

        shifting = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData);
        tick_end = (tick_q == TickLast);
        byte_end = shifting && tick_end && (bit_q == 3'd7);

        if (state_q != StIdle) begin
            tick_d = tick_end ? '0 : tick_q + 1'b1;
        end
        if (shifting && tick_end) begin
            bit_d = bit_q + 3'd1;
        end
        if (shifting && (tick_q == TickHalf)) begin
            rx_d = {rx_q[6:0], miso};
            // The 8th sample completes a byte; it appears on the outputs next cycle.
            if ((state_q == StData) && !wr_q && (bit_q == 3'd7)) begin
                rd_valid_d = 1'b1;
                rd_data_d  = {rx_q[6:0], miso};
                rd_last_d  = (left_q == 3'd1);
            end
        end

        if (req_wr[gnt_id] || (len_sel == 3'd0)) begin
            n_sel = 3'd1;
        end else if (len_sel > MaxLen) begin
            n_sel = MaxLen;
        end

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StCsSetup;
                    tick_d  = '0;
                    bit_d   = 3'd0;
                    id_d    = gnt_id;
                    last_d  = gnt_id;
                    wr_d    = req_wr[gnt_id];
                    addr_d  = gnt_id ? req_addr[15:8] : req_addr[7:0];
                    wdata_d = gnt_id ? req_wdata[15:8] : req_wdata[7:0];
                    left_d  = n_sel;
                end
            end
            StCsSetup: if (tick_end) state_d = StCmd;
            StCmd:     if (byte_end) state_d = StAddr;
            StAddr:    if (byte_end) state_d = StData;
            StData: begin
                if (byte_end) begin
                    if (left_q == 3'd1) state_d = StCsHold;
                    else                left_d  = left_q - 3'd1;
                end
            end
            StCsHold:  if (tick_end) state_d = StGap;
            StGap:     if (tick_end) state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        // Pin outputs are decoded from the next state so the registered pins line up
        // with the bit phase of the state they belong to.
        sending = (state_d == StCmd) || (state_d == StAddr) || (state_d == StData);
        unique case (state_d)
            StCmd:   tx_byte = wr_d ? 8'h0A : 8'h0B;
            StAddr:  tx_byte = addr_d;
            StData:  tx_byte = wr_d ? wdata_d : 8'h00;
            default: tx_byte = 8'h00;
        endcase
        mosi_d = sending && tx_byte[~bit_d];
        sclk_d = sending && (tick_d >= TickHalf);
        csn_d  = (state_d == StIdle) || (state_d == StGap);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StGap) && (state_q != StGap);
    end

    always_ff @(posedge clk_8mhz or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_q      <= 3'd0;
            left_q     <= 3'd0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
            wr_q       <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            rx_q       <= 8'h00;
            csn_q      <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            left_q     <= left_d;
            id_q       <= id_d;
            last_q     <= last_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rx_q       <= rx_d;
            csn_q      <= csn_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
        end
    end

    assign csn      = csn_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign busy     = busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_id    = id_q;
    assign rd_last  = rd_last_q;
    assign done     = done_q;

endmodule

// File: tb/tb_acl_spi_sched.sv
// Bench for acl_spi_sched: random and directed requests, an SPI slave model and a
// frame monitor that compares every transaction against a transaction-level model.
module tb_acl_spi_sched;

    localparam int TICK    = 8;
    localparam int MAX_LEN = 6;
    localparam int NEXP    = 64;

    logic        clk_8mhz = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0, req_ready, req_wr = '0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic [5:0]  req_len = '0;
    logic        busy, rd_valid, rd_id, rd_last, done, miso, mosi, sclk, csn;
    logic [7:0]  rd_data;

    acl_spi_sched #(.TICK(TICK), .MAX_LEN(MAX_LEN)) dut (
        .clk_8mhz (clk_8mhz),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_len  (req_len),
        .busy     (busy),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_id    (rd_id),
        .rd_last  (rd_last),
        .done     (done),
        .miso     (miso),
        .mosi     (mosi),
        .sclk     (sclk),
        .csn      (csn)
    );

    always #5 clk_8mhz = ~clk_8mhz;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    endtask

    // Pending request fields per requester.
    logic       f_wr [2];
    logic [7:0] f_addr [2];
    logic [7:0] f_wd [2];
    logic [2:0] f_len [2];
    logic [7:0] f_sd [2][8];

    // Expected transactions in grant order.
    int         exp_cnt = 0;
    int         n_abort = 0;
    logic       exp_wr [NEXP];
    int         exp_id [NEXP];
    logic [7:0] exp_addr [NEXP];
    logic [7:0] exp_wd [NEXP];
    int         exp_n [NEXP];
    bit         exp_abort [NEXP];
    logic [7:0] exp_sd [NEXP][8];
    int         m_last = 1;

    function automatic int model_len(input logic wr, input logic [2:0] len);
        if (wr || len == 3'd0) return 1;
        if (int'(len) > MAX_LEN) return MAX_LEN;
        return int'(len);
    endfunction

    task automatic sync();
        @(posedge clk_8mhz);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [7:0] addr,
                           input logic [7:0] wd, input logic [2:0] len, input logic [7:0] sd0);
        f_wr[i] = wr;
        f_addr[i] = addr;
        f_wd[i] = wd;
        f_len[i] = len;
        for (int k = 0; k < 8; k++) f_sd[i][k] = 8'(sd0 + 8'(k) * 8'h11);
        req_wr[i] = wr;
        req_addr[8*i +: 8] = addr;
        req_wdata[8*i +: 8] = wd;
        req_len[3*i +: 3] = len;
        req_valid[i] = 1'b1;
    endtask

    // Called at a negedge: if a grant is offered, check it against the model and record it.
    task automatic poll_grant();
        int win;
        logic [1:0] want;
        if (req_ready != 2'b00) begin
            if (req_valid == 2'b11) win = (m_last == 1) ? 0 : 1;
            else win = req_valid[1] ? 1 : 0;
            want = (req_valid == 2'b00) ? 2'b00 : (2'b01 << win);
            check("grant", {30'd0, req_ready}, {30'd0, want});
            check("ready_only_idle", busy, 0);
            m_last = win;
            if (exp_cnt < NEXP) begin
                exp_wr[exp_cnt] = f_wr[win];
                exp_id[exp_cnt] = win;
                exp_addr[exp_cnt] = f_addr[win];
                exp_wd[exp_cnt] = f_wd[win];
                exp_n[exp_cnt] = model_len(f_wr[win], f_len[win]);
                exp_abort[exp_cnt] = 1'b0;
                for (int k = 0; k < 8; k++) exp_sd[exp_cnt][k] = f_sd[win][k];
                exp_cnt++;
            end
            @(posedge clk_8mhz);
            #1;
            req_valid[win] = 1'b0;
            check("csn_after_grant", csn, 0);
            check("busy_after_grant", busy, 1);
        end
    endtask

    int mon_frames = 0;
    int mon_nbits  = 0;
    int done_total = 0;

    // Runs until every pending request has been granted and its frame has finished.
    task automatic serve();
        bit ok = 1'b0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(negedge clk_8mhz);
            poll_grant();
            if (req_valid == 2'b00 && !busy && mon_frames == exp_cnt) begin
                ok = 1'b1;
                break;
            end
        end
        check("serve_timeout", ok, 1);
    endtask

    // SPI slave (mode 0): next bit after each falling sclk, first bit at csn fall.
    int s_frame = 0;
    int s_bit   = 0;
    bit s_prev_cs = 1'b1;
    initial begin
        logic [7:0] b;
        miso = 1'b0;
        forever begin
            @(csn or negedge sclk);
            if (csn !== 1'b0) begin
                if (!s_prev_cs) s_frame++;
                s_bit = 0;
                miso = 1'b0;
            end else begin
                if (s_prev_cs) s_bit = 0;
                else s_bit++;
                if (s_bit >= 16 && s_bit < 80 && s_frame < NEXP) begin
                    b = exp_sd[s_frame][s_bit/8 - 2];
                    miso = b[7 - s_bit % 8];
                end else begin
                    miso = 1'b0;
                end
            end
            s_prev_cs = (csn !== 1'b0);
        end
    end

    // Frame monitor, sampling on the inactive clock edge.
    initial begin
        bit prev_csn = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, seen = 1'b0;
        int lo_cnt = 0, hi_cnt = 0, last_hi = 0, rd_n = 0, f, n;
        logic [7:0] mb [10];
        logic [7:0] rdd [16];
        logic rdi [16], rdl [16];
        forever begin
            @(negedge clk_8mhz);
            if (csn === 1'b0) begin
                if (prev_csn) begin
                    if (seen) check("csn_high_min", hi_cnt >= TICK, 1);
                    lo_cnt = 0;
                    mon_nbits = 0;
                    rd_n = 0;
                    last_hi = 0;
                    for (int k = 0; k < 10; k++) mb[k] = 8'h00;
                end
                lo_cnt++;
                if (sclk) last_hi = lo_cnt;
                if (sclk && !prev_sclk) begin
                    check("sclk_rise_phase", (lo_cnt - 1) % TICK, TICK / 2);
                    check("sclk_after_setup", lo_cnt > TICK, 1);
                    if (mon_nbits < 80) mb[mon_nbits/8] = {mb[mon_nbits/8][6:0], mosi};
                    mon_nbits++;
                end
                if (!prev_csn && mosi !== prev_mosi) begin
                    check("mosi_change_phase", (lo_cnt - 1) % TICK, 0);
                end
            end else begin
                if (!prev_csn) begin
                    f = mon_frames;
                    if (f >= NEXP || f >= exp_cnt) begin
                        check("unexpected_frame", f, exp_cnt);
                    end else if (exp_abort[f]) begin
                        check("abort_no_done", done, 0);
                    end else begin
                        n = exp_n[f];
                        check("done_pulse", done, 1);
                        check("csn_low_len", lo_cnt, 2*TICK + (2+n)*8*TICK);
                        check("sclk_low_hold", lo_cnt - last_hi, TICK);
                        check("sclk_rises", mon_nbits, (2+n)*8);
                        check("mosi_cmd", mb[0], exp_wr[f] ? 8'h0A : 8'h0B);
                        check("mosi_addr", mb[1], exp_addr[f]);
                        for (int k = 0; k < n; k++)
                            check("mosi_data", mb[2+k], exp_wr[f] ? exp_wd[f] : 8'h00);
                        check("rd_count", rd_n, exp_wr[f] ? 0 : n);
                        for (int k = 0; k < n && k < rd_n && k < 16; k++) begin
                            check("rd_data", rdd[k], exp_sd[f][k]);
                            check("rd_id", rdi[k], exp_id[f]);
                            check("rd_last", rdl[k], k == n - 1);
                        end
                    end
                    seen = 1'b1;
                    hi_cnt = 0;
                    mon_frames++;
                end
                hi_cnt++;
                if (hi_cnt <= TICK) check("sclk_idle", sclk, 0);
            end
            if (rd_valid) begin
                if (rd_n < 16) begin
                    rdd[rd_n] = rd_data;
                    rdi[rd_n] = rd_id;
                    rdl[rd_n] = rd_last;
                end
                rd_n++;
            end
            if (done) done_total++;
            prev_csn = (csn !== 1'b0);
            prev_sclk = sclk;
            prev_mosi = mosi;
        end
    end

    initial begin
        int q, base;
        bit ok;
        logic [1:0] mask;

        #12;
        check("rst_csn", csn, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_id", rd_id, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_done", done, 0);
        req_valid = 2'b11;
        #1;
        check("rst_ready_masked", req_ready, 0);
        req_valid = 2'b00;
        @(negedge clk_8mhz);
        rst = 1'b0;

        // Directed write and read from the test plan.
        sync(); set_req(0, 1'b1, 8'h2D, 8'h02, 3'd0, 8'h00); serve();
        sync(); set_req(1, 1'b0, 8'h0E, 8'h00, 3'd6, 8'h11); serve();

        // Simultaneous requests.
        repeat (3) begin
            sync();
            set_req(0, 1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 8'($urandom));
            set_req(1, 1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 8'($urandom));
            serve();
        end

        // Length clamping boundaries.
        sync(); set_req(0, 1'b0, 8'h08, 8'h00, 3'd0, 8'($urandom)); serve();
        sync(); set_req(1, 1'b0, 8'h08, 8'h00, 3'd7, 8'($urandom)); serve();

        // Random traffic.
        repeat (12) begin
            mask = 2'($urandom_range(1, 3));
            sync();
            for (int i = 0; i < 2; i++)
                if (mask[i]) set_req(i, 1'($urandom), 8'($urandom), 8'($urandom),
                                     3'($urandom_range(0, 7)), 8'($urandom));
            serve();
        end

        // Reset in the 3rd DATA byte of a 6-byte read.
        base = exp_cnt;
        sync(); set_req(0, 1'b0, 8'h0E, 8'h00, 3'd6, 8'hA5);
        ok = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk_8mhz);
            poll_grant();
            if (exp_cnt == base + 1) begin ok = 1'b1; break; end
        end
        check("abort_grant", ok, 1);
        ok = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_8mhz);
            if (mon_nbits >= 8*4 + 3) begin ok = 1'b1; break; end
        end
        check("abort_reach_byte3", ok, 1);
        if (exp_cnt > 0) exp_abort[exp_cnt-1] = 1'b1;
        n_abort++;
        #2;
        rst = 1'b1;
        #1;
        check("abort_csn", csn, 1);
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        m_last = 1;
        q = 0;
        repeat (5) begin
            @(negedge clk_8mhz);
            if (rd_valid || done) q++;
        end
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk_8mhz);
            if (rd_valid || done) q++;
        end
        check("abort_quiet", q, 0);
        check("abort_frame_closed", mon_frames, exp_cnt);

        sync(); set_req(1, 1'b0, 8'h0E, 8'h00, 3'd6, 8'h3C); serve();

        check("done_total", done_total, exp_cnt - n_abort);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
